arb_stream_rx: RTL and testbench



---
 rtl/arb_link_pkg.sv | 36 +++
 rtl/sat_counter.sv | 33 +++
 rtl/arb_stream_rx.sv | 152 +++++++++++++++
 tb/tb_arb_stream_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_link_pkg.sv
// Link-level constants, field positions and FSM state shared by the arbitter
// transmitter and the arb_stream_rx receiver.
package arb_link_pkg;

    localparam int NCHAN    = 16;
    localparam int MAXLEN   = 2047;
    localparam int CHAN_W   = 4;
    localparam int LEN_W    = 11;
    localparam int WORD_W   = 16;

    localparam int KCODE_LSB = 0;
    localparam int CHAN_LSB  = 8;
    localparam int LEN_LSB   = 0;

    localparam logic [7:0] K_SOB  = 8'h1C;
    localparam logic [7:0] K_IDLE = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA
    } link_state_e;

    function automatic logic chan_legal(input logic [CHAN_W-1:0] chan);
        return 32'(chan) < 32'(NCHAN);
    endfunction

    // Length word must have clean upper bits and a length in 1..MAXLEN.
    function automatic logic len_legal(input logic [WORD_W-1:0] word);
        logic [LEN_W-1:0] len;
        len = word[LEN_LSB +: LEN_W];
        return (word[WORD_W-1:LEN_LSB+LEN_W] == '0) && (len != '0) &&
               (32'(len) <= 32'(MAXLEN));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that either saturates at all-ones or wraps, selected by a mode bit.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             saturate,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(saturate && (&count_q))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/arb_stream_rx.sv
// Receiver for the arbitter link: delineates blocks, tags payload words with
// their channel and counts framing errors and completed blocks.
module arb_stream_rx
    import arb_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        kin,
    output logic [15:0] dout,
    output logic [3:0]  dchan,
    output logic        dvalid,
    output logic        dsob,
    output logic        deob,
    output logic        err,
    output logic [15:0] errcnt,
    output logic [31:0] blkcnt
);

    link_state_e        state_q, state_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic               first_q, first_d;
    logic [15:0]        dout_q, dout_d;
    logic [3:0]         dchan_q, dchan_d;
    logic               dvalid_q, dvalid_d;
    logic               dsob_q, dsob_d;
    logic               deob_q, deob_d;
    logic               err_q, err_d;
    logic               blk_done_d;

    logic               is_sob;
    logic               is_idle;
    logic [CHAN_W-1:0]  sob_chan;

    assign sob_chan = din[CHAN_LSB +: CHAN_W];
    assign is_sob   = kin && (din[KCODE_LSB +: 8] == K_SOB) &&
                      (din[15:CHAN_LSB+CHAN_W] == '0);
    assign is_idle  = kin && (din[KCODE_LSB +: 8] == K_IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        remain_d   = remain_q;
        first_d    = first_q;
        dout_d     = '0;
        dchan_d    = '0;
        dvalid_d   = 1'b0;
        dsob_d     = 1'b0;
        deob_d     = 1'b0;
        err_d      = 1'b0;
        blk_done_d = 1'b0;

        if (is_sob) begin
            // An SOB anywhere restarts framing; outside IDLE it also truncates.
            err_d = (state_q != ST_IDLE);
            if (chan_legal(sob_chan)) begin
                chan_d  = sob_chan;
                state_d = ST_LEN;
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (kin) begin
            err_d   = (state_q != ST_IDLE) || !is_idle;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    err_d = 1'b1;
                end
                ST_LEN: begin
                    if (len_legal(din)) begin
                        remain_d = din[LEN_LSB +: LEN_W];
                        first_d  = 1'b1;
                        state_d  = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    dout_d   = din;
                    dchan_d  = chan_q;
                    dvalid_d = 1'b1;
                    dsob_d   = first_q;
                    first_d  = 1'b0;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        deob_d     = 1'b1;
                        blk_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            chan_q   <= '0;
            remain_q <= '0;
            first_q  <= 1'b0;
            dout_q   <= '0;
            dchan_q  <= '0;
            dvalid_q <= 1'b0;
            dsob_q   <= 1'b0;
            deob_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            remain_q <= remain_d;
            first_q  <= first_d;
            dout_q   <= dout_d;
            dchan_q  <= dchan_d;
            dvalid_q <= dvalid_d;
            dsob_q   <= dsob_d;
            deob_q   <= deob_d;
            err_q    <= err_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_errcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (err_d),
        .saturate (1'b1),
        .count    (errcnt)
    );

    sat_counter #(.WIDTH(32)) u_blkcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (blk_done_d),
        .saturate (1'b0),
        .count    (blkcnt)
    );

    assign dout   = dout_q;
    assign dchan  = dchan_q;
    assign dvalid = dvalid_q;
    assign dsob   = dsob_q;
    assign deob   = deob_q;
    assign err    = err_q;

endmodule

// File: tb/tb_arb_stream_rx.sv
// Scoreboard bench for arb_stream_rx: each driven word pushes the output it
// must produce one clock later; the next sample pops and compares it.
module tb_arb_stream_rx;
    import arb_link_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        kin;
    logic [15:0] dout;
    logic [3:0]  dchan;
    logic        dvalid;
    logic        dsob;
    logic        deob;
    logic        err;
    logic [15:0] errcnt;
    logic [31:0] blkcnt;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [3:0]  c;
        logic        s;
        logic        e;
        logic        er;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    arb_stream_rx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .kin    (kin),
        .dout   (dout),
        .dchan  (dchan),
        .dvalid (dvalid),
        .dsob   (dsob),
        .deob   (deob),
        .err    (err),
        .errcnt (errcnt),
        .blkcnt (blkcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check("dvalid", 32'(dvalid), 32'(x.v));
            check("err", 32'(err), 32'(x.er));
            check("dsob", 32'(dsob), 32'(x.s));
            check("deob", 32'(deob), 32'(x.e));
            if (x.v) begin
                check("dout", 32'(dout), 32'(x.d));
                check("dchan", 32'(dchan), 32'(x.c));
            end
        end
    endtask

    task automatic send(input logic [15:0] w, input logic k, input logic ev,
                        input logic [3:0] ec, input logic es, input logic ee,
                        input logic eer);
        exp_t x;
        @(negedge clk);
        sample();
        din = w;
        kin = k;
        x.v = ev; x.d = w; x.c = ec; x.s = es; x.e = ee; x.er = eer;
        sb.push_back(x);
    endtask

    task automatic idle_w(input int n);
        for (int i = 0; i < n; i++) send({8'h00, K_IDLE}, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sob_w(input logic [3:0] ch, input logic eer);
        send({4'h0, ch, K_SOB}, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, eer);
    endtask

    task automatic len_w(input logic [15:0] w, input logic eer);
        send(w, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, eer);
    endtask

    // Words n_first..n_first+cnt-1 of an L-word block on channel ch.
    task automatic data_w(input logic [3:0] ch, input int len, input int n_first,
                          input int cnt, input logic [15:0] base);
        for (int i = n_first; i < n_first + cnt; i++)
            send(base + 16'(i), 1'b0, 1'b1, ch, (i == 0), (i == len - 1), 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        sample();
    endtask

    task automatic check_counts(input string tag, input int e_err, input int e_blk);
        check({tag, "_errcnt"}, 32'(errcnt), 32'(e_err));
        check({tag, "_blkcnt"}, blkcnt, 32'(e_blk));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_dchan"}, 32'(dchan), 32'h0);
        check({tag, "_dvalid"}, 32'(dvalid), 32'h0);
        check({tag, "_dsob"}, 32'(dsob), 32'h0);
        check({tag, "_deob"}, 32'(deob), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check_counts(tag, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        sample();
        sb.delete();
        rst_n = 1'b0;
        din   = {8'h00, K_IDLE};
        kin   = 1'b1;
        #1;
        check_zero(tag);
        @(negedge clk);
        @(negedge clk);
        check_zero(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        din   = {8'h00, K_IDLE};
        kin   = 1'b1;
        #1;
        do_reset("por");

        // Good block, channel 2, length 10
        idle_w(5);
        sob_w(4'd2, 1'b0);
        len_w(16'd10, 1'b0);
        data_w(4'd2, 10, 0, 10, 16'h0000);
        idle_w(1);
        settle();
        check_counts("good", 0, 1);

        // Length one on the highest channel
        do_reset("rst_l1");
        sob_w(4'd15, 1'b0);
        len_w(16'd1, 1'b0);
        send(16'hABCD, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
        idle_w(1);
        settle();
        check_counts("len1", 0, 1);

        // Truncated block interrupted by a new SOB
        do_reset("rst_trunc");
        sob_w(4'd3, 1'b0);
        len_w(16'd8, 1'b0);
        data_w(4'd3, 8, 0, 4, 16'h3000);
        sob_w(4'd4, 1'b1);
        len_w(16'd2, 1'b0);
        data_w(4'd4, 2, 0, 2, 16'h4000);
        idle_w(1);
        settle();
        check_counts("trunc", 1, 1);

        // Zero length, then a normal block
        do_reset("rst_len0");
        sob_w(4'd5, 1'b0);
        len_w(16'd0, 1'b1);
        idle_w(2);
        sob_w(4'd5, 1'b0);
        len_w(16'd3, 1'b0);
        data_w(4'd5, 3, 0, 3, 16'h5550);
        idle_w(1);
        settle();
        check_counts("len0", 1, 1);

        // Stray data word in IDLE
        do_reset("rst_stray");
        idle_w(1);
        send(16'h1234, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle_w(2);
        settle();
        check_counts("stray", 1, 0);

        // Dirty length upper bits, idle K in LEN, idle K truncating DATA
        do_reset("rst_misc");
        sob_w(4'd6, 1'b0);
        len_w(16'h0803, 1'b1);
        sob_w(4'd7, 1'b0);
        send({8'h00, K_IDLE}, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        sob_w(4'd8, 1'b0);
        len_w(16'd5, 1'b0);
        data_w(4'd8, 5, 0, 2, 16'h8000);
        send({8'h00, K_IDLE}, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        send(16'h8002, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle_w(1);
        settle();
        check_counts("misc", 4, 0);

        // Reset after 3 of 10 words; only the following block is delivered
        do_reset("rst_mid0");
        sob_w(4'd9, 1'b0);
        len_w(16'd10, 1'b0);
        data_w(4'd9, 10, 0, 3, 16'h9000);
        do_reset("rst_mid");
        data_w(4'd9, 10, 3, 0, 16'h9000);
        idle_w(1);
        send(16'h9003, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle_w(1);
        settle();
        check_counts("mid_stray", 1, 0);
        do_reset("rst_mid2");
        sob_w(4'd10, 1'b0);
        len_w(16'd4, 1'b0);
        data_w(4'd10, 4, 0, 4, 16'hA000);
        idle_w(1);
        settle();
        check_counts("mid_after", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
